fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hazard stall from ID; IF/ID register shall hold when high.
REQ-005 DoBranch  input  1  redirect request from branch control in ID.
REQ-006 BranchAddress  input  32  redirect target from branch control.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  fetch address (current PC).
REQ-009 imem_ready  input  1  memory returns valid imem_rdata this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 if_id_instruction  output  32  IF/ID instruction register.
REQ-012 if_id_pc4  output  32  IF/ID PC+4 register (feeds the branch-target adder in ID).
REQ-013 if_id_valid  output  1  IF/ID content is a real instruction; 0 = bubble.

Function
REQ-014 The block SHALL hold the PC, a one-entry hold buffer, redirect_addr, and a 3-state FSM: FETCH, DRAIN, HOLD.
REQ-015 imem_addr SHALL equal the PC; imem_req SHALL be 1 in FETCH and DRAIN, 0 in HOLD, and 0 while reset is high.
REQ-016 Once imem_req is high, imem_addr SHALL stay constant until a cycle with imem_ready=1.
REQ-017 PC arithmetic: 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0; BranchAddress[1:0] is forced to 2'b00 when loaded.
REQ-018 DoBranch has priority over stall and over every other event, in every state.
REQ-019 FETCH, DoBranch=1, imem_ready=1: drop rdata; PC<=BranchAddress; if_id_valid<=0; stay FETCH.
REQ-020 FETCH, DoBranch=1, imem_ready=0: redirect_addr<=BranchAddress; if_id_valid<=0; go DRAIN.
REQ-021 FETCH, imem_ready=1, stall=0: if_id_instruction<=imem_rdata; if_id_pc4<=PC+4; if_id_valid<=1; PC<=PC+4.
REQ-022 FETCH, imem_ready=1, stall=1: hold buffer<=imem_rdata; IF/ID unchanged; go HOLD.
REQ-023 FETCH, imem_ready=0: if stall=0, if_id_valid<=0 (bubble); if stall=1, IF/ID unchanged.
REQ-024 DRAIN: imem_rdata is discarded; a new DoBranch overwrites redirect_addr (latest wins); on imem_ready=1, PC<=redirect_addr and go FETCH; if_id_valid stays 0.
REQ-025 HOLD, stall=0: IF/ID<=hold buffer, PC+4, valid=1; PC<=PC+4; go FETCH; a new request issues the following cycle.
REQ-026 HOLD, stall=1: all state unchanged.
REQ-027 Best-case throughput SHALL be one instruction per cycle with a zero-wait memory: fetch-to-IF/ID latency is 1 clock edge.
REQ-028 No branch delay slot: any instruction fetched but not yet in IF/ID at DoBranch is discarded.

Reset
REQ-029 On reset: PC=RESET_PC, FSM=FETCH, if_id_instruction=0, if_id_pc4=0, if_id_valid=0, hold buffer=0, redirect_addr=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; the first request after reset deassertion is at RESET_PC.
REQ-031 imem_req SHALL go high in the first cycle after reset deasserts.

Verification
REQ-032 Zero-wait stream: reset, imem_ready=1, rdata=PC-tagged -> IF/ID pc4 sequence 4, 8, 12; valid=1 every cycle from the 2nd edge.
REQ-033 Stall with data: at PC=8, stall=1 for 3 cycles while ready=1 -> HOLD, imem_req=0, IF/ID holds PC4=8 entry; after release IF/ID pc4=12, next imem_addr=12.
REQ-034 Redirect while waiting: imem_ready=0 at PC=16, DoBranch=1 with target 0x100, then ready after 2 cycles -> returned word dropped, valid=0, next imem_addr=0x100.
REQ-035 Double redirect in DRAIN: targets 0x100 then 0x200 before ready -> next imem_addr=0x200.
REQ-036 Boundaries: BranchAddress=0xFFFF_FFFE -> PC=0xFFFF_FFFC; next sequential fetch at 0x0, if_id_pc4=0x0; DoBranch+stall same cycle in HOLD -> buffer dropped, PC=target.
REQ-037 Async reset mid-DRAIN -> outputs at reset values immediately without a clock edge; first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage with an IF/ID pipeline register. It keeps the PC,
// issues one instruction-memory request at a time and holds the address steady
// until the memory answers. It handles ID-stage stalls and branch redirects.
//
//   FETCH : a request is outstanding at PC.
//   DRAIN : a redirect arrived while a request was in flight. The returning
//           word is thrown away, then fetching resumes at redirect_addr.
//   HOLD  : a word arrived while ID was stalled. It waits in the hold buffer
//           and no new request is issued until the stall clears.
//
// Ports
//   clk               in   clock, rising edge
//   reset             in   asynchronous, active-high reset
//   stall             in   hazard stall from ID; IF/ID holds while high
//   DoBranch          in   redirect request from ID (highest priority)
//   BranchAddress     in   redirect target; bits [1:0] are ignored
//   imem_req          out  instruction memory request
//   imem_addr         out  fetch address (the PC)
//   imem_ready        in   imem_rdata is valid this cycle
//   imem_rdata        in   fetched instruction word
//   if_id_instruction out  IF/ID instruction register
//   if_id_pc4         out  IF/ID PC+4 register
//   if_id_valid       out  IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        DoBranch,
    input  logic [31:0] BranchAddress,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] hold_buf, hold_buf_next;
    logic [31:0] redirect_addr, redirect_next;
    logic [31:0] instr_next, pc4_next;
    logic        valid_next;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    // Modulo-2^32 arithmetic: 0xFFFF_FFFC + 4 wraps to 0.
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = BranchAddress & ~32'd3;

    // The request is gated by reset so that the memory sees no request while
    // reset is held. The asynchronous reset forces the state to FETCH.
    assign imem_req  = (state != HOLD) && !reset;
    assign imem_addr = pc;

    // NOTE: every signal driven here gets a default first. This means no path
    // leaves a value unassigned, so no latch is inferred.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        hold_buf_next = hold_buf;
        redirect_next = redirect_addr;
        instr_next    = if_id_instruction;
        pc4_next      = if_id_pc4;
        valid_next    = if_id_valid;

        case (state)
            FETCH: begin
                if (DoBranch) begin
                    valid_next = 1'b0;
                    if (imem_ready) begin
                        pc_next = branch_target;            // returned word dropped
                    end else begin
                        redirect_next = branch_target;      // wait for the in-flight word
                        state_next    = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (!stall) begin
                        instr_next = imem_rdata;
                        pc4_next   = pc_plus4;
                        valid_next = 1'b1;
                        pc_next    = pc_plus4;
                    end else begin
                        hold_buf_next = imem_rdata;
                        state_next    = HOLD;
                    end
                end else if (!stall) begin
                    valid_next = 1'b0;                      // bubble while memory waits
                end
            end

            DRAIN: begin
                // If DoBranch and imem_ready arrive together, the newest
                // target wins and is used directly.
                if (DoBranch) begin
                    if (imem_ready) begin
                        pc_next    = branch_target;
                        state_next = FETCH;
                    end else begin
                        redirect_next = branch_target;
                    end
                end else if (imem_ready) begin
                    pc_next    = redirect_addr;
                    state_next = FETCH;
                end
            end

            HOLD: begin
                if (DoBranch) begin
                    pc_next    = branch_target;             // buffered word discarded
                    valid_next = 1'b0;
                    state_next = FETCH;
                end else if (!stall) begin
                    instr_next = hold_buf;
                    pc4_next   = pc_plus4;
                    valid_next = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = FETCH;
                end
            end

            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments. This way every
    // register samples the values from before the edge, whatever the order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                <= RESET_PC;
            hold_buf          <= '0;
            redirect_addr     <= '0;
            if_id_instruction <= '0;
            if_id_pc4         <= '0;
            if_id_valid       <= 1'b0;
        end else begin
            pc                <= pc_next;
            hold_buf          <= hold_buf_next;
            redirect_addr     <= redirect_next;
            if_id_instruction <= instr_next;
            if_id_pc4         <= pc4_next;
            if_id_valid       <= valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. It has three parts:
//   1. A table of directed vectors: zero-wait stream, stall into HOLD,
//      redirect while waiting, double redirect, address wrap, and a branch
//      during HOLD.
//   2. A hand-written asynchronous reset asserted in the middle of DRAIN.
//   3. Randomized stimulus compared against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        DoBranch;
    logic [31:0] BranchAddress;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .DoBranch          (DoBranch),
        .BranchAddress     (BranchAddress),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .if_id_instruction (if_id_instruction),
        .if_id_pc4         (if_id_pc4),
        .if_id_valid       (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
        check({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
        check({tag, ".addr"},  imem_addr,            addr);
        check({tag, ".instr"}, if_id_instruction,    instr);
        check({tag, ".pc4"},   if_id_pc4,            pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    // Each vector's inputs are applied for one clock. The expected fields are
    // the outputs just after that clock edge.
    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] ba;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] ba,
                                input logic r, input logic [31:0] d, input logic eq,
                                input logic [31:0] ea, input logic [31:0] ei,
                                input logic [31:0] ep, input logic ev);
        vec_t v;
        v.stall = s;  v.br = b;  v.ba = ba;  v.rdy = r;  v.rdata = d;
        v.e_req = eq; v.e_addr = ea; v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev;
        return v;
    endfunction

    task automatic drive(input logic s, input logic b, input logic [31:0] ba,
                         input logic r, input logic [31:0] d);
        stall = s; DoBranch = b; BranchAddress = ba; imem_ready = r; imem_rdata = d;
    endtask

    // Transaction-level reference model used for the random phase.
    logic [31:0] m_pc, m_instr, m_pc4, m_redir;
    logic        m_valid;
    bit          m_discard;     // an in-flight word must be thrown away
    logic [31:0] m_held[$];     // fetched word waiting for ID to accept it

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_redir = 32'h0; m_discard = 0; m_held.delete();
    endtask

    task automatic model_step(input logic s, input logic b, input logic [31:0] ba,
                              input logic r, input logic [31:0] d);
        logic [31:0] tgt;
        bit          in_flight;
        tgt       = {ba[31:2], 2'b00};
        in_flight = (m_held.size() == 0);   // a request is out unless a word is held
        if (b) begin
            m_valid = 1'b0;
            m_held.delete();
            if (in_flight && !r) begin
                m_discard = 1;
                m_redir   = tgt;
            end else begin
                m_discard = 0;
                m_pc      = tgt;
            end
        end else if (m_discard) begin
            if (r) begin
                m_pc      = m_redir;
                m_discard = 0;
            end
        end else if (m_held.size() != 0) begin
            if (!s) begin
                m_instr = m_held.pop_front();
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end else if (r) begin
            if (!s) begin
                m_instr = d;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end else begin
                m_held.push_back(d);
            end
        end else if (!s) begin
            m_valid = 1'b0;
        end
    endtask

    vec_t vecs[19];

    initial begin
        //               st br ba            rdy rdata         req addr          instr         pc4           valid
        vecs[0]  = mk(0, 0, 32'h0,         1, 32'hC000_0000, 1, 32'h4,        32'hC000_0000, 32'h4,        1);
        vecs[1]  = mk(0, 0, 32'h0,         1, 32'hC000_0004, 1, 32'h8,        32'hC000_0004, 32'h8,        1);
        vecs[2]  = mk(1, 0, 32'h0,         1, 32'hC000_0008, 0, 32'h8,        32'hC000_0004, 32'h8,        1);
        vecs[3]  = mk(1, 0, 32'h0,         1, 32'hEEEE_0001, 0, 32'h8,        32'hC000_0004, 32'h8,        1);
        vecs[4]  = mk(1, 0, 32'h0,         1, 32'hEEEE_0002, 0, 32'h8,        32'hC000_0004, 32'h8,        1);
        vecs[5]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'hC,        32'hC000_0008, 32'hC,        1);
        vecs[6]  = mk(0, 0, 32'h0,         1, 32'hC000_000C, 1, 32'h10,       32'hC000_000C, 32'h10,       1);
        vecs[7]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h10,       32'hC000_000C, 32'h10,       0);
        vecs[8]  = mk(0, 1, 32'h100,       0, 32'h0,         1, 32'h10,       32'hC000_000C, 32'h10,       0);
        vecs[9]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h10,       32'hC000_000C, 32'h10,       0);
        vecs[10] = mk(0, 0, 32'h0,         1, 32'hC000_0010, 1, 32'h100,      32'hC000_000C, 32'h10,       0);
        vecs[11] = mk(0, 1, 32'h100,       0, 32'h0,         1, 32'h100,      32'hC000_000C, 32'h10,       0);
        vecs[12] = mk(0, 1, 32'h200,       0, 32'h0,         1, 32'h100,      32'hC000_000C, 32'h10,       0);
        vecs[13] = mk(0, 0, 32'h0,         1, 32'hBAD0_0100, 1, 32'h200,      32'hC000_000C, 32'h10,       0);
        vecs[14] = mk(0, 1, 32'hFFFF_FFFE, 1, 32'hBAD0_0200, 1, 32'hFFFF_FFFC, 32'hC000_000C, 32'h10,       0);
        vecs[15] = mk(0, 0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h0,        32'hDEAD_BEEF, 32'h0,        1);
        vecs[16] = mk(1, 0, 32'h0,         1, 32'h1234_5678, 0, 32'h0,        32'hDEAD_BEEF, 32'h0,        1);
        vecs[17] = mk(1, 1, 32'h300,       0, 32'h0,         1, 32'h300,      32'hDEAD_BEEF, 32'h0,        0);
        vecs[18] = mk(0, 0, 32'h0,         1, 32'hAAAA_0000, 1, 32'h304,      32'hAAAA_0000, 32'h304,      1);

        // Reset state. The request must stay low while reset is held.
        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // The request must rise in the first cycle after reset deasserts.
        reset = 1'b0;
        #1;
        check("post_reset.req",  {31'd0, imem_req}, 32'd1);
        check("post_reset.addr", imem_addr,         32'h0);

        // Directed vectors.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].br, vecs[i].ba, vecs[i].rdy, vecs[i].rdata);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                      vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_valid);
        end

        // Asynchronous reset in the middle of DRAIN.
        @(negedge clk);
        drive(0, 1, 32'h400, 0, 32'h0);          // redirect while waiting -> DRAIN
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h0);
        #2;
        reset = 1'b1;                            // no clock edge before checking
        #1;
        check_all("async_reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("after_async.req",  {31'd0, imem_req}, 32'd1);
        check("after_async.addr", imem_addr,         32'h0);

        // Randomized run against the reference model.
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic        s, b, r;
            logic [31:0] ba, d;
            @(negedge clk);
            check_all($sformatf("rnd%0d", c), (m_held.size() == 0), m_pc, m_instr, m_pc4, m_valid);
            s  = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 1) == 1);
            ba = $urandom;
            d  = $urandom;
            drive(s, b, ba, r, d);
            model_step(s, b, ba, r, d);
        end
        @(negedge clk);
        check_all("rnd_final", (m_held.size() == 0), m_pc, m_instr, m_pc4, m_valid);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
